mux_self_test: RTL and testbench

Sequential stimulus driver and response checker for the 2:1 mux stage. It sits directly upstream of the mux, driving `sel`, `in1` and `in2`, and directly downstream of it, consuming the mux output. On `start` it walks all 8 input combinations, waits a programmable settle time, samples the mux output, and compares it against the golden function `sel ? in1 : in2`. It reports the captured response vector, the mismatch count and pass/fail, with a start/busy/done handshake.

---
 rtl/mux_test_pkg.sv | 17 +
 rtl/mux.sv | 11 +
 rtl/mux_test_top.sv | 42 ++++
 rtl/mux_self_test.sv | 99 +++++++++
 tb/tb_mux_self_test.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_test_pkg.sv
// Shared types and golden model for the 2:1 mux self-test.
package mux_test_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam int N_PAT = 8;

    function automatic logic mux_golden(input logic sel, input logic in1, input logic in2);
        return sel ? in1 : in2;
    endfunction

endpackage

// File: rtl/mux.sv
// Plain 2:1 multiplexer stage exercised by the self-test.
module mux (
    input  logic sel,
    input  logic in1,
    input  logic in2,
    output logic out
);

    assign out = sel ? in1 : in2;

endmodule

// File: rtl/mux_test_top.sv
// Integration wrapper: self-test sequencer wired around a real mux stage.
module mux_test_top #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic [3:0] err_cnt,
    output logic       pass
);

    logic sel_s;
    logic in1_s;
    logic in2_s;
    logic out_s;

    mux_self_test #(.SETTLE(SETTLE)) u_test (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .sel     (sel_s),
        .in1     (in1_s),
        .in2     (in2_s),
        .mux_out (out_s),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .err_cnt (err_cnt),
        .pass    (pass)
    );

    mux u_mux (
        .sel (sel_s),
        .in1 (in1_s),
        .in2 (in2_s),
        .out (out_s)
    );

endmodule

// File: rtl/mux_self_test.sv
// Walks all eight {sel,in1,in2} patterns, samples the mux after a settle delay,
// and scores the responses against the golden mux function.
module mux_self_test
    import mux_test_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       sel,
    output logic       in1,
    output logic       in2,
    input  logic       mux_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic [3:0] err_cnt,
    output logic       pass
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state_r;
    logic [2:0] k_r;
    logic [3:0] cnt_r;

    // Sequencer: every output is a register, so mux_out never reaches a port combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            k_r     <= 3'd0;
            cnt_r   <= 4'd0;
            sel     <= 1'b0;
            in1     <= 1'b0;
            in2     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= 8'h00;
            err_cnt <= 4'd0;
            pass    <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        k_r             <= 3'd0;
                        {sel, in1, in2} <= 3'b000;
                        result          <= 8'h00;
                        err_cnt         <= 4'd0;
                        pass            <= 1'b0;
                        cnt_r           <= 4'd0;
                        busy            <= 1'b1;
                        state_r         <= S_SETTLE;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt_r == SETTLE_LAST) begin
                        cnt_r   <= 4'd0;
                        state_r <= S_SAMPLE;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                S_SAMPLE: begin
                    result[k_r] <= mux_out;
                    if (mux_out != mux_golden(k_r[2], k_r[1], k_r[0])) begin
                        err_cnt <= err_cnt + 4'd1;
                    end else begin
                        err_cnt <= err_cnt;
                    end
                    if (k_r == 3'(N_PAT - 1)) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        k_r             <= k_r + 3'd1;
                        {sel, in1, in2} <= k_r + 3'd1;
                        state_r         <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    // err_cnt is final here: the last SAMPLE update landed on the previous edge.
                    done    <= 1'b0;
                    pass    <= (err_cnt == 4'd0);
                    state_r <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_self_test.sv
// Directed bench for mux_self_test with a behavioural mux (good, stuck-at-0, swapped)
// and a scoreboard of expected run results popped on each done pulse.
module tb_mux_self_test;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, start3;
    logic       sel1, in1_1, in2_1, mux_out1, busy1, done1, pass1;
    logic       sel3, in1_3, in2_3, mux_out3, busy3, done3, pass3;
    logic [7:0] result1, result3;
    logic [3:0] err1, err3;
    int         mode;

    typedef struct {
        logic [7:0] res;
        logic [3:0] err;
        logic       pass;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];

    int vectors = 0;
    int miscompares = 0;
    int edge_cnt = 0;
    int c0_1 = 0, c0_3 = 0;
    int done_cnt1 = 0, done_cnt3 = 0;
    int done_cyc1 = 0, done_cyc3 = 0;
    int last_done1 = 0, gap1 = 0;
    logic pend1 = 1'b0, pend3 = 1'b0;
    logic pexp1 = 1'b0, pexp3 = 1'b0;
    logic [2:0] prev_pat = 3'd0;
    int hold_len = 0;
    logic run3 = 1'b0;

    always #5 clk = ~clk;

    function automatic logic mux_model(input int m, input logic s, input logic a, input logic b);
        case (m)
            0:       return s ? a : b;
            1:       return 1'b0;
            default: return s ? b : a;
        endcase
    endfunction

    function automatic exp_t expect_run(input int m);
        exp_t e;
        logic [2:0] kv;
        logic g, o;
        e.res = 8'h00;
        e.err = 4'd0;
        for (int k = 0; k < 8; k++) begin
            kv = 3'(k);
            g = kv[2] ? kv[1] : kv[0];
            o = mux_model(m, kv[2], kv[1], kv[0]);
            e.res[k] = o;
            if (o != g) e.err = e.err + 4'd1;
        end
        e.pass = (e.err == 4'd0);
        return e;
    endfunction

    assign mux_out1 = mux_model(mode, sel1, in1_1, in2_1);
    assign mux_out3 = mux_model(mode, sel3, in1_3, in2_3);

    mux_self_test #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .sel(sel1), .in1(in1_1), .in2(in2_1),
        .mux_out(mux_out1), .busy(busy1), .done(done1), .result(result1),
        .err_cnt(err1), .pass(pass1)
    );

    mux_self_test #(.SETTLE(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .sel(sel3), .in1(in1_3), .in2(in2_3),
        .mux_out(mux_out3), .busy(busy3), .done(done3), .result(result3),
        .err_cnt(err3), .pass(pass3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Scoreboard for the SETTLE=1 instance.
    always @(negedge clk) begin
        if (pend1) begin
            check("pass1", 32'(pass1), 32'(pexp1));
            pend1 = 1'b0;
        end
        if (done1 === 1'b1) begin
            done_cnt1++;
            gap1 = edge_cnt - last_done1;
            last_done1 = edge_cnt;
            done_cyc1 = edge_cnt - c0_1 + 1;
            check("done1_expected", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) begin
                exp_t e;
                e = q1.pop_front();
                check("result1", 32'(result1), 32'(e.res));
                check("err_cnt1", 32'(err1), 32'(e.err));
                pexp1 = e.pass;
                pend1 = 1'b1;
            end
        end
    end

    // Scoreboard and pattern-hold tracking for the SETTLE=3 instance.
    always @(negedge clk) begin
        if (pend3) begin
            check("pass3", 32'(pass3), 32'(pexp3));
            pend3 = 1'b0;
        end
        if (busy3 === 1'b1) begin
            if (!run3) begin
                check("first_pat3", 32'({sel3, in1_3, in2_3}), 32'd0);
                run3 = 1'b1;
                hold_len = 1;
            end else if ({sel3, in1_3, in2_3} == prev_pat) begin
                hold_len++;
            end else begin
                check("hold_len3", 32'(hold_len), 32'd4);
                check("next_pat3", 32'({sel3, in1_3, in2_3}), 32'(prev_pat + 3'd1));
                hold_len = 1;
            end
            prev_pat = {sel3, in1_3, in2_3};
        end else if (run3) begin
            check("last_hold3", 32'(hold_len), 32'd4);
            run3 = 1'b0;
        end
        if (done3 === 1'b1) begin
            done_cnt3++;
            done_cyc3 = edge_cnt - c0_3 + 1;
            check("done3_expected", 32'(q3.size() != 0), 32'd1);
            if (q3.size() != 0) begin
                exp_t e;
                e = q3.pop_front();
                check("result3", 32'(result3), 32'(e.res));
                check("err_cnt3", 32'(err3), 32'(e.err));
                pexp3 = e.pass;
                pend3 = 1'b1;
            end
        end
    end

    task automatic pulse1();
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        c0_1 = edge_cnt;
    endtask

    task automatic wait_done1(input int target, input string tag);
        int n = 0;
        while (done_cnt1 < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(done_cnt1 >= target), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [31:0] outs1();
        return 32'({sel1, in1_1, in2_1, busy1, done1, pass1, err1, result1});
    endfunction

    initial begin
        int base;
        int n;
        rst = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        mode = 0;
        repeat (3) @(negedge clk);
        check("reset_outs1", outs1(), 32'd0);
        check("reset_outs3", 32'({sel3, in1_3, in2_3, busy3, done3, pass3, err3, result3}), 32'd0);
        rst = 1'b0;

        // Good mux, single start pulse.
        mode = 0;
        q1.push_back(expect_run(0));
        pulse1();
        check("busy_after_start", 32'(busy1), 32'd1);
        wait_done1(1, "timeout_good");
        check("done_cycle1", 32'(done_cyc1), 32'd17);

        // Stuck-at-0 mux.
        mode = 1;
        q1.push_back(expect_run(1));
        pulse1();
        wait_done1(2, "timeout_stuck");

        // Swapped data inputs.
        mode = 2;
        q1.push_back(expect_run(2));
        pulse1();
        wait_done1(3, "timeout_swap");

        // Abort mid-run with an asynchronous reset at k=3.
        mode = 0;
        pulse1();
        n = 0;
        while ({sel1, in1_1, in2_1} != 3'd3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_k3", 32'({sel1, in1_1, in2_1}), 32'd3);
        base = done_cnt1;
        #2 rst = 1'b1;
        #1 check("async_rst_outs", outs1(), 32'd0);
        repeat (3) @(negedge clk);
        check("rst_held_outs", outs1(), 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("no_done_after_abort", 32'(done_cnt1), 32'(base));
        q1.push_back(expect_run(0));
        pulse1();
        wait_done1(base + 1, "timeout_after_abort");

        // Start held high: back-to-back runs, start ignored while busy.
        base = done_cnt1;
        q1.push_back(expect_run(0));
        q1.push_back(expect_run(0));
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        c0_1 = edge_cnt;
        n = 0;
        while (done_cnt1 < base + 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("held_first_done_cycle", 32'(done_cyc1), 32'd17);
        n = 0;
        while (done_cnt1 < base + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        start1 = 1'b0;
        check("timeout_held", 32'(done_cnt1 >= base + 2), 32'd1);
        check("held_done_gap", 32'(gap1), 32'd18);
        repeat (25) @(negedge clk);
        check("held_run_count", 32'(done_cnt1), 32'(base + 2));

        // Longer settle time on the second instance.
        mode = 0;
        q3.push_back(expect_run(0));
        @(negedge clk);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        c0_3 = edge_cnt;
        n = 0;
        while (done_cnt3 < 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("timeout_settle3", 32'(done_cnt3 >= 1), 32'd1);
        check("done_cycle3", 32'(done_cyc3), 32'd33);
        repeat (3) @(negedge clk);

        check("q1_drained", 32'(q1.size()), 32'd0);
        check("q3_drained", 32'(q3.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
